// File: rtl/bmu_search_seq.sv
// bmu_search_seq: pipelined best-matching-unit search over LANES x BEATS candidates.
// Stage 1 reduces each beat over its lanes; stage 2 folds that into the running best.
module bmu_search_seq #(
    parameter int DIST_W   = 10,
    parameter int WGT_W    = 24,
    parameter int LANES    = 8,
    parameter int BEATS    = 8,
    parameter bit TIE_HIGH = 1'b1,
    localparam int XW = $clog2(LANES),
    localparam int YW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DIST_W-1:0] in_dist,
    input  logic [LANES*WGT_W-1:0]  in_weight,
    output logic                    busy,
    output logic                    out_valid,
    output logic [XW-1:0]           X_c,
    output logic [YW-1:0]           Y_c,
    output logic [WGT_W-1:0]        weight_c,
    output logic [DIST_W-1:0]       dist_c
);
    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;
    state_t state, state_nx;
    logic [YW-1:0] beat_cnt;
    logic accept, last_beat;
    logic [DIST_W-1:0] lane_dist, s1_dist, best_dist;
    logic [XW-1:0] lane_idx, s1_idx, best_x;
    logic [WGT_W-1:0] lane_wgt, s1_wgt, best_wgt;
    logic [YW-1:0] s1_beat, best_y;
    logic s1_valid, best_valid, take;
    assign accept    = in_valid && in_ready;
    assign last_beat = beat_cnt == YW'(BEATS - 1);
    assign busy      = state != IDLE;
    always_comb begin
        in_ready = state == ACCUM;
        state_nx = state == IDLE  ? (start ? ACCUM : IDLE) :
                   state == ACCUM ? ((accept && last_beat) ? FLUSH : ACCUM) : IDLE;
    end
    // Sequential scan gives the same winner as a tree under a consistent tie rule.
    always_comb begin
        lane_dist = in_dist[0 +: DIST_W];
        lane_wgt  = in_weight[0 +: WGT_W];
        lane_idx  = '0;
        for (int i = 1; i < LANES; i++) begin
            if (TIE_HIGH ? (in_dist[i*DIST_W +: DIST_W] <= lane_dist)
                         : (in_dist[i*DIST_W +: DIST_W] <  lane_dist)) begin
                lane_dist = in_dist[i*DIST_W +: DIST_W];
                lane_wgt  = in_weight[i*WGT_W +: WGT_W];
                lane_idx  = XW'(i);
            end
        end
    end
    assign take = s1_valid && (!best_valid ||
                  (TIE_HIGH ? (s1_dist <= best_dist) : (s1_dist < best_dist)));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            s1_valid   <= 1'b0;
            s1_dist    <= '0;
            s1_idx     <= '0;
            s1_wgt     <= '0;
            s1_beat    <= '0;
            best_valid <= 1'b0;
            best_dist  <= '0;
            best_x     <= '0;
            best_y     <= '0;
            best_wgt   <= '0;
            out_valid  <= 1'b0;
            X_c        <= '0;
            Y_c        <= '0;
            weight_c   <= '0;
            dist_c     <= '0;
        end else begin
            state    <= state_nx;
            s1_valid <= accept;
            if (state == IDLE && start)
                beat_cnt <= '0;
            else if (accept)
                beat_cnt <= beat_cnt + 1'b1;
            if (accept) begin
                s1_dist <= lane_dist;
                s1_idx  <= lane_idx;
                s1_wgt  <= lane_wgt;
                s1_beat <= beat_cnt;
            end
            if (state == IDLE && start)
                best_valid <= 1'b0;
            else if (s1_valid)
                best_valid <= 1'b1;
            if (take) begin
                best_dist <= s1_dist;
                best_x    <= s1_idx;
                best_y    <= s1_beat;
                best_wgt  <= s1_wgt;
            end
            out_valid <= state == FLUSH;
            // The last beat merges in FLUSH, so the result is taken from the merge path.
            if (state == FLUSH) begin
                X_c      <= take ? s1_idx  : best_x;
                Y_c      <= take ? s1_beat : best_y;
                weight_c <= take ? s1_wgt  : best_wgt;
                dist_c   <= take ? s1_dist : best_dist;
            end
        end
    end
endmodule

// File: tb/tb_bmu_search_seq.sv
// tb_bmu_search_seq: randomized scoreboard bench driving tie-high and tie-low instances in lockstep.
module tb_bmu_search_seq;
    localparam int DW = 10, WW = 24, L = 8, B = 8;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [L*DW-1:0] in_dist = '0;
    logic [L*WW-1:0] in_weight = '0;
    logic in_ready_h, busy_h, ov_h, in_ready_l, busy_l, ov_l;
    logic [2:0] x_h, y_h, x_l, y_l;
    logic [WW-1:0] w_h, w_l;
    logic [DW-1:0] d_h, d_l;

    typedef struct {
        int x;
        int y;
        logic [WW-1:0] w;
        logic [DW-1:0] d;
        int cyc;
    } exp_t;
    exp_t q_h[$], q_l[$];
    logic [DW-1:0] dm[B][L];
    logic [WW-1:0] wm[B][L];
    int checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bmu_search_seq #(.DIST_W(DW), .WGT_W(WW), .LANES(L), .BEATS(B), .TIE_HIGH(1'b1)) dut_h (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_h),
        .in_dist(in_dist), .in_weight(in_weight), .busy(busy_h), .out_valid(ov_h),
        .X_c(x_h), .Y_c(y_h), .weight_c(w_h), .dist_c(d_h));
    bmu_search_seq #(.DIST_W(DW), .WGT_W(WW), .LANES(L), .BEATS(B), .TIE_HIGH(1'b0)) dut_l (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_dist(in_dist), .in_weight(in_weight), .busy(busy_l), .out_valid(ov_l),
        .X_c(x_l), .Y_c(y_l), .weight_c(w_l), .dist_c(d_l));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Winner = minimum distance; among equals, last (tie-high) or first (tie-low) in beat-major order.
    function automatic exp_t model(input bit th, input int c);
        exp_t e;
        logic [DW-1:0] mn = '1;
        bit found = 0;
        e = '{x: 0, y: 0, w: '0, d: '0, cyc: c};
        for (int b = 0; b < B; b++)
            for (int l = 0; l < L; l++)
                if (dm[b][l] < mn) mn = dm[b][l];
        e.d = mn;
        for (int b = 0; b < B; b++)
            for (int l = 0; l < L; l++)
                if (dm[b][l] == mn && (th || !found)) begin
                    e.x = l; e.y = b; e.w = wm[b][l]; found = 1;
                end
        return e;
    endfunction

    task automatic cmp(input string tag, input exp_t e, input int x, input int y,
                       input logic [WW-1:0] w, input logic [DW-1:0] d, input logic bz);
        check({tag, "_x"}, x, e.x);
        check({tag, "_y"}, y, e.y);
        check({tag, "_weight"}, w, e.w);
        check({tag, "_dist"}, d, e.d);
        check({tag, "_latency_cycle"}, cyc, e.cyc);
        check({tag, "_busy_at_result"}, bz, 0);
    endtask

    always @(negedge clk) if (rst) begin
        if (ov_h) begin
            if (q_h.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_out_valid_high got 1 expected 0 at cycle %0d", cyc);
            end else cmp("high", q_h.pop_front(), x_h, y_h, w_h, d_h, busy_h);
        end
        if (ov_l) begin
            if (q_l.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_out_valid_low got 1 expected 0 at cycle %0d", cyc);
            end else cmp("low", q_l.pop_front(), x_l, y_l, w_l, d_l, busy_l);
        end
    end

    task automatic fill(input int mode);
        for (int b = 0; b < B; b++)
            for (int l = 0; l < L; l++) begin
                case (mode)
                    0: begin dm[b][l] = DW'($urandom_range(0, 40)); wm[b][l] = WW'($urandom); end
                    1: begin
                        dm[b][l] = (b == 6 && l == 3) ? DW'(5) : DW'(100);
                        wm[b][l] = (b == 6 && l == 3) ? 24'hABCDEF : WW'($urandom);
                    end
                    2: begin dm[b][l] = DW'(7); wm[b][l] = WW'(b * 256 + l); end
                    default: begin dm[b][l] = 10'h3FF; wm[b][l] = WW'($urandom); end
                endcase
            end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, {in_ready_h, in_ready_l}, 0);
        check({tag, "_busy"}, {busy_h, busy_l}, 0);
        check({tag, "_out_valid"}, {ov_h, ov_l}, 0);
        check({tag, "_xy"}, {x_h, y_h, x_l, y_l}, 0);
        check({tag, "_weight"}, {w_h, w_l}, 0);
        check({tag, "_dist"}, {d_h, d_l}, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {busy_h, busy_l}, 2'b11);
        check("ready_after_start", {in_ready_h, in_ready_l}, 2'b11);
    endtask

    task automatic drive(input int gap, input int mid_start_at, input int abort_after);
        for (int b = 0; b < B; b++) begin
            if (b == abort_after) begin
                rst = 1'b0; in_valid = 1'b0;
                #2;
                check_zero("abort");
                @(posedge clk); #1;
                rst = 1'b1;
                return;
            end
            while ($urandom_range(99) < gap) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            for (int l = 0; l < L; l++) begin
                in_dist[l*DW +: DW] = dm[b][l];
                in_weight[l*WW +: WW] = wm[b][l];
            end
            start = (b == mid_start_at);
            begin
                int g = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (!in_ready_h && g < 20);
                check("beat_accepted", {in_ready_h, in_ready_l}, 2'b11);
            end
            if (b == B - 1) begin
                q_h.push_back(model(1'b1, cyc + 2));
                q_l.push_back(model(1'b0, cyc + 2));
            end
            @(posedge clk); #1;
            in_valid = 1'b0; start = 1'b0;
        end
        check("flush_ready_low", {in_ready_h, in_ready_l}, 0);
        check("flush_busy", {busy_h, busy_l}, 2'b11);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        idle(3);
        rst = 1'b1;
        idle(5);
        check_zero("reset");
        in_valid = 1'b1;
        repeat (4) begin
            in_dist = {L{DW'($urandom_range(0, 9))}};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        idle(3);
        check_zero("idle_pulses");

        fill(1); do_start(); drive(0, -1, -1); idle(4);
        fill(2); do_start(); drive(0, -1, -1); idle(4);
        fill(3); do_start(); drive(0, -1, -1); idle(4);
        repeat (6) begin
            fill(0); do_start(); drive(50, 3, -1); idle(4);
        end

        fill(0); do_start(); drive(0, -1, 4);
        check_zero("post_abort");
        fill(0); do_start(); drive(0, -1, -1); idle(4);

        fill(0); do_start(); drive(0, -1, -1);
        @(posedge clk); #1;
        check("b2b_out_valid", {ov_h, ov_l}, 2'b11);
        fill(0); do_start(); drive(30, -1, -1); idle(5);

        check("queue_high_drained", q_h.size(), 0);
        check("queue_low_drained", q_l.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
